// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants and helper functions
// Purpose: default geometry/threshold constants and a constant-foldable clog2
//          shared by all FIFO flavours in this codebase.
// Ports:   none (package)
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 512;
  localparam int AF_LEVEL_DEF   = 510;
  localparam int AE_LEVEL_DEF   = 2;

  // Ceiling log2, usable in parameter expressions. clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_flagged_if.sv
// rtl/sync_fifo_flagged_if.sv - producer/consumer bus of the flagged sync FIFO
// Purpose: bundles the request, data, flag and status signals of sync_fifo_flagged.
// Ports:   master = producer/consumer side (drives wr_en, rd_en, din)
//          slave  = FIFO side (drives dout, flags, pulses and count)
interface sync_fifo_flagged_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF,
  parameter int CNT_W = clog2(FIFO_DEPTH_DEF + 1)
);

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             wr_ack;
  logic             overflow;
  logic             underflow;
  logic [CNT_W-1:0] count;

  modport master (
    output wr_en, rd_en, din,
    input  dout, full, empty, almost_full, almost_empty,
           wr_ack, overflow, underflow, count
  );

  modport slave (
    input  wr_en, rd_en, din,
    output dout, full, empty, almost_full, almost_empty,
           wr_ack, overflow, underflow, count
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - simple dual-port storage with registered read port
// Purpose: FIFO word array, one write port and one read port whose output
//          register is the FIFO dout. Array contents are never reset.
// Ports:   clk, rst          clock, sync active-high reset (clears rd_data only)
//          wr_en/addr/data   write port, stores on the rising edge
//          rd_en/addr        read request; rd_data updates on that edge
//          rd_data           registered read data, holds when rd_en is low
module sync_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512,
  parameter int PTR_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_d, rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // A read of the word being overwritten on the same edge returns the old
  // word, which is what a full FIFO doing read+write needs.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_flagged.sv
// rtl/sync_fifo_flagged.sv - single-clock FIFO with thresholds, count and status pulses
// Purpose: same-domain buffer between a producer and a consumer; any depth >= 2.
// Ports:   clk  single rising-edge clock
//          rst  synchronous active-high reset, wins over requests
//          bus  slave side of sync_fifo_flagged_if: wr_en/rd_en/din in;
//               dout, full/empty/almost_full/almost_empty, wr_ack/overflow/
//               underflow pulses and count out
module sync_fifo_flagged
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL   = AF_LEVEL_DEF,
  parameter int AE_LEVEL   = AE_LEVEL_DEF
) (
  input logic                clk,
  input logic                rst,
  sync_fifo_flagged_if.slave bus
);

  localparam int PTR_W = clog2(FIFO_DEPTH);
  localparam int CNT_W = clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             wr_ack_d, wr_ack_q;
  logic             overflow_d, overflow_q;
  logic             underflow_d, underflow_q;
  logic             full, empty;
  logic             rd_accept, wr_accept;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_accept = bus.rd_en & ~empty;
  assign wr_accept = bus.wr_en & (~full | rd_accept);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = wr_accept;
    overflow_d  = bus.wr_en & ~wr_accept;
    underflow_d = bus.rd_en & ~rd_accept;

    // Explicit wrap so non-power-of-two depths work.
    if (wr_accept) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    if (rd_accept) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);

    if (wr_accept && !rd_accept)      count_d = count_q + CNT_W'(1);
    else if (rd_accept && !wr_accept) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept & ~rst),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.din),
    .rd_en   (rd_accept & ~rst),
    .rd_addr (rd_ptr_q),
    .rd_data (bus.dout)
  );

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CNT_AF);
  assign bus.almost_empty = (count_q <= CNT_AE);
  assign bus.wr_ack       = wr_ack_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.count        = count_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// tb/tb_sync_fifo_flagged.sv - directed self-checking bench for sync_fifo_flagged
module tb_sync_fifo_flagged;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sync_fifo_flagged_if #(.WIDTH(16), .CNT_W(4)) bus8 ();
  sync_fifo_flagged_if #(.WIDTH(16), .CNT_W(3)) bus6 ();

  sync_fifo_flagged #(
    .FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  sync_fifo_flagged #(
    .FIFO_WIDTH(16), .FIFO_DEPTH(6), .AF_LEVEL(5), .AE_LEVEL(1)
  ) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of requests to the depth-8 FIFO and sample 1 time unit after the edge.
  task automatic step8(input logic w, input logic r, input logic [15:0] d);
    bus8.wr_en = w;
    bus8.rd_en = r;
    bus8.din   = d;
    @(posedge clk);
    #1;
    bus8.wr_en = 1'b0;
    bus8.rd_en = 1'b0;
  endtask

  task automatic step6(input logic w, input logic r, input logic [15:0] d);
    bus6.wr_en = w;
    bus6.rd_en = r;
    bus6.din   = d;
    @(posedge clk);
    #1;
    bus6.wr_en = 1'b0;
    bus6.rd_en = 1'b0;
  endtask

  initial begin
    bus6.wr_en = 1'b0;
    bus6.rd_en = 1'b0;
    bus6.din   = '0;

    // 1. reset with requests asserted
    rst = 1'b1;
    step8(1'b1, 1'b1, 16'hFFFF);
    chk("rst_count", 32'(bus8.count), 0);
    chk("rst_empty", 32'(bus8.empty), 1);
    chk("rst_aempty", 32'(bus8.almost_empty), 1);
    chk("rst_full", 32'(bus8.full), 0);
    chk("rst_afull", 32'(bus8.almost_full), 0);
    chk("rst_dout", 32'(bus8.dout), 0);
    chk("rst_wr_ack", 32'(bus8.wr_ack), 0);
    chk("rst_overflow", 32'(bus8.overflow), 0);
    chk("rst_underflow", 32'(bus8.underflow), 0);
    rst = 1'b0;

    // 2. fill 1..8, then one rejected write
    for (int i = 1; i <= 8; i++) begin
      step8(1'b1, 1'b0, 16'(i));
      chk($sformatf("fill%0d_ack", i), 32'(bus8.wr_ack), 1);
      chk($sformatf("fill%0d_count", i), 32'(bus8.count), 32'(i));
      chk($sformatf("fill%0d_ae", i), 32'(bus8.almost_empty), (i <= 2) ? 1 : 0);
      chk($sformatf("fill%0d_af", i), 32'(bus8.almost_full), (i >= 6) ? 1 : 0);
      chk($sformatf("fill%0d_full", i), 32'(bus8.full), (i == 8) ? 1 : 0);
    end
    step8(1'b1, 1'b0, 16'h0009);
    chk("ovf_pulse", 32'(bus8.overflow), 1);
    chk("ovf_ack", 32'(bus8.wr_ack), 0);
    chk("ovf_count", 32'(bus8.count), 8);
    step8(1'b0, 1'b0, 16'h0000);
    chk("ovf_clear", 32'(bus8.overflow), 0);
    chk("ack_clear", 32'(bus8.wr_ack), 0);

    // 3. drain 8, then one rejected read
    for (int i = 1; i <= 8; i++) begin
      step8(1'b0, 1'b1, 16'h0000);
      chk($sformatf("drain%0d_dout", i), 32'(bus8.dout), 32'(i));
      chk($sformatf("drain%0d_count", i), 32'(bus8.count), 32'(8 - i));
      chk($sformatf("drain%0d_unf", i), 32'(bus8.underflow), 0);
    end
    step8(1'b0, 1'b1, 16'h0000);
    chk("unf_pulse", 32'(bus8.underflow), 1);
    chk("unf_dout_hold", 32'(bus8.dout), 16'h0008);
    chk("unf_empty", 32'(bus8.empty), 1);

    // 5a. simultaneous read+write at full
    for (int i = 0; i < 8; i++) step8(1'b1, 1'b0, 16'(16'h0010 + i));
    chk("sim_full_pre", 32'(bus8.full), 1);
    step8(1'b1, 1'b1, 16'hAAAA);
    chk("sim_full_count", 32'(bus8.count), 8);
    chk("sim_full_dout", 32'(bus8.dout), 16'h0010);
    chk("sim_full_ack", 32'(bus8.wr_ack), 1);
    chk("sim_full_ovf", 32'(bus8.overflow), 0);
    for (int i = 1; i <= 7; i++) begin
      step8(1'b0, 1'b1, 16'h0000);
      chk($sformatf("sim_drain%0d", i), 32'(bus8.dout), 32'(16'h0010 + i));
    end
    step8(1'b0, 1'b1, 16'h0000);
    chk("sim_last_aaaa", 32'(bus8.dout), 16'hAAAA);
    chk("sim_empty", 32'(bus8.empty), 1);

    // 5b. simultaneous read+write at empty
    step8(1'b1, 1'b1, 16'h5555);
    chk("sim_empty_count", 32'(bus8.count), 1);
    chk("sim_empty_unf", 32'(bus8.underflow), 1);
    chk("sim_empty_ack", 32'(bus8.wr_ack), 1);
    chk("sim_empty_dout", 32'(bus8.dout), 16'hAAAA);
    step8(1'b0, 1'b1, 16'h0000);
    chk("sim_5555_dout", 32'(bus8.dout), 16'h5555);
    chk("sim_5555_count", 32'(bus8.count), 0);

    // 4. wrap on depth-6 instance: write 4, read 4, write 6, read 6
    for (int i = 0; i < 4; i++) step6(1'b1, 1'b0, 16'(16'h0100 + i));
    chk("wrap_cnt4", 32'(bus6.count), 4);
    for (int i = 0; i < 4; i++) begin
      step6(1'b0, 1'b1, 16'h0000);
      chk($sformatf("wrap_a%0d", i), 32'(bus6.dout), 32'(16'h0100 + i));
    end
    for (int i = 0; i < 6; i++) begin
      step6(1'b1, 1'b0, 16'(16'h0200 + i));
      chk($sformatf("wrap_full%0d", i), 32'(bus6.full), (i == 5) ? 1 : 0);
    end
    chk("wrap_cnt6", 32'(bus6.count), 6);
    chk("wrap_af", 32'(bus6.almost_full), 1);
    for (int i = 0; i < 6; i++) begin
      step6(1'b0, 1'b1, 16'h0000);
      chk($sformatf("wrap_b%0d", i), 32'(bus6.dout), 32'(16'h0200 + i));
    end
    chk("wrap_empty", 32'(bus6.empty), 1);

    // 6. mid-operation reset at count=5
    for (int i = 0; i < 5; i++) step8(1'b1, 1'b0, 16'(16'h0300 + i));
    step8(1'b0, 1'b1, 16'h0000);
    chk("mid_pre_dout", 32'(bus8.dout), 16'h0300);
    step8(1'b1, 1'b0, 16'h0305);
    chk("mid_pre_count", 32'(bus8.count), 5);
    rst = 1'b1;
    step8(1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    chk("mid_count", 32'(bus8.count), 0);
    chk("mid_empty", 32'(bus8.empty), 1);
    chk("mid_dout", 32'(bus8.dout), 0);
    step8(1'b0, 1'b1, 16'h0000);
    chk("mid_unf", 32'(bus8.underflow), 1);
    chk("mid_unf_count", 32'(bus8.count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
